// File: rtl/shf_wb_ctl_pkg.sv
// Shared definitions for the shifter writeback path: status bit positions and
// shifter operation class codes.
package shf_wb_ctl_pkg;

    localparam int SHF_STAT_SZ = 0;
    localparam int SHF_STAT_SV = 1;
    localparam int SHF_STAT_SS = 2;

    typedef enum logic [1:0] {
        SHF_ASH = 2'b00,
        SHF_ROT = 2'b01,
        SHF_LZ  = 2'b10,
        SHF_LO  = 2'b11
    } shf_cls_e;

endpackage

// File: rtl/shf_wb_fifo.sv
// Writeback buffer: DEPTH-entry FIFO of {dest address, data}. A push into a full
// buffer is accepted only when a pop happens on the same edge.
module shf_wb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != FULL) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/shf_wb_ctl.sv
// Shifter consumer: tracks issued ops, captures result and flags one cycle later,
// buffers them and writes them back to the register file over a req/grant port.
module shf_wb_ctl
    import shf_wb_ctl_pkg::*;
#(
    parameter int DATASIZE = 16,
    parameter int ADDRSIZE = 4,
    parameter int DEPTH    = 2
) (
    input  logic                clk_exe,
    input  logic                reset,
    input  logic                ps_shf_en,
    input  logic [ADDRSIZE-1:0] ps_shf_rn,
    input  logic                ps_ss_clr,
    input  logic [DATASIZE-1:0] shf_xb_dt,
    input  logic                shf_ps_sv,
    input  logic                shf_ps_sz,
    input  logic                rf_shf_gnt,
    output logic                shf_rf_we,
    output logic [ADDRSIZE-1:0] shf_rf_addr,
    output logic [DATASIZE-1:0] shf_rf_dt,
    output logic [2:0]          shf_ps_stat,
    output logic                shf_ps_stall
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDRSIZE + DATASIZE;

    logic                r_v1;
    logic [ADDRSIZE-1:0] r_rn_d;
    logic [2:0]          r_stat;
    logic [CW-1:0]       w_count;
    logic [EW-1:0]       w_head;
    logic                w_nonempty;
    logic                w_stall;

    // Stall counts the in-flight op so it always has a slot when it lands.
    assign w_stall    = ({1'b0, w_count} + (CW + 1)'(r_v1)) >= (CW + 1)'(DEPTH);
    assign w_nonempty = (w_count != '0);

    always_ff @(posedge clk_exe or negedge reset) begin
        if (!reset) begin
            r_v1   <= 1'b0;
            r_rn_d <= '0;
            r_stat <= 3'b000;
        end else begin
            r_v1 <= ps_shf_en & ~w_stall;
            if (ps_shf_en & ~w_stall) begin
                r_rn_d <= ps_shf_rn;
            end
            if (r_v1) begin
                r_stat[SHF_STAT_SZ] <= shf_ps_sz;
                r_stat[SHF_STAT_SV] <= shf_ps_sv;
            end
            // A capture setting SS beats a simultaneous clear.
            r_stat[SHF_STAT_SS] <= (r_stat[SHF_STAT_SS] & ~ps_ss_clr) | (r_v1 & shf_ps_sv);
        end
    end

    shf_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_exe),
        .rst_n   (reset),
        .i_push  (r_v1),
        .i_din   ({r_rn_d, shf_xb_dt}),
        .i_pop   (rf_shf_gnt),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign shf_rf_we    = w_nonempty;
    assign shf_rf_addr  = w_nonempty ? w_head[EW-1:DATASIZE] : '0;
    assign shf_rf_dt    = w_nonempty ? w_head[DATASIZE-1:0] : '0;
    assign shf_ps_stat  = r_stat;
    assign shf_ps_stall = w_stall;

endmodule

// File: tb/tb_shf_wb_ctl.sv
// Bench for shf_wb_ctl: a shifter reference model feeds results; writes are checked
// in order against an expected queue by a negedge monitor.
module tb_shf_wb_ctl;
    import shf_wb_ctl_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] rn;
    logic          clr;
    logic [DW-1:0] xb_dt;
    logic          sv_in;
    logic          sz_in;
    logic          gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dt;
    logic [2:0]    stat;
    logic          stall;

    logic [AW+DW-1:0] exp_q[$];
    logic [2:0]       exp_stat;
    logic             pend_v;
    logic [17:0]      pend_res;
    int               n_chk;
    int               n_fail;

    shf_wb_ctl #(.DATASIZE(DW), .ADDRSIZE(AW), .DEPTH(DEPTH)) dut (
        .clk_exe      (clk),
        .reset        (rst_n),
        .ps_shf_en    (en),
        .ps_shf_rn    (rn),
        .ps_ss_clr    (clr),
        .shf_xb_dt    (xb_dt),
        .shf_ps_sv    (sv_in),
        .shf_ps_sz    (sz_in),
        .rf_shf_gnt   (gnt),
        .shf_rf_we    (we),
        .shf_rf_addr  (addr),
        .shf_rf_dt    (dt),
        .shf_ps_stat  (stat),
        .shf_ps_stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shifter: returns {sv, sz, result}.
    function automatic logic [17:0] shf_model(shf_cls_e cls, logic [15:0] x, logic [15:0] y);
        logic [15:0]        res;
        logic               sv;
        logic [47:0]        wide;
        logic signed [15:0] xs;
        int                 sh;
        int                 n;
        res = '0;
        sv  = 1'b0;
        xs  = x;
        case (cls)
            SHF_ASH: begin
                sh = int'($signed(y));
                if (sh >= 0) begin
                    if (sh > 31) sh = 31;
                    wide = {{32{x[15]}}, x} << sh;
                    res  = wide[15:0];
                    sv   = (wide != {{32{res[15]}}, res});
                end else begin
                    n = -sh;
                    if (n > 15) n = 15;
                    res = xs >>> n;
                end
            end
            SHF_ROT: begin
                n   = int'(y[3:0]);
                res = (x << n) | (x >> (16 - n));
            end
            SHF_LZ: begin
                res = 16'd16;
                for (int i = 0; i < 16; i++) if (x[i]) res = 16'(15 - i);
                sv = (x == 16'h0000);
            end
            default: begin
                res = 16'd16;
                for (int i = 0; i < 16; i++) if (!x[i]) res = 16'(15 - i);
                sv = (x == 16'hffff);
            end
        endcase
        return {sv, (res == 16'h0000), res};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle, called just after a posedge. Models what the edge does.
    task automatic step(input logic do_en, input logic [AW-1:0] r, input shf_cls_e cls,
                        input logic [15:0] x, input logic [15:0] y, input logic c, input logic g);
        logic [17:0] res;
        en  = do_en;
        rn  = r;
        clr = c;
        gnt = g;
        if (pend_v) begin
            {sv_in, sz_in, xb_dt} = pend_res;
        end else begin
            {sv_in, sz_in, xb_dt} = 18'($urandom);
        end
        @(posedge clk);
        if (pend_v) begin
            exp_stat[SHF_STAT_SZ] = pend_res[16];
            exp_stat[SHF_STAT_SV] = pend_res[17];
            exp_stat[SHF_STAT_SS] = (exp_stat[SHF_STAT_SS] & ~c) | pend_res[17];
        end else if (c) begin
            exp_stat[SHF_STAT_SS] = 1'b0;
        end
        pend_v = do_en;
        if (do_en) begin
            res      = shf_model(cls, x, y);
            pend_res = res;
            exp_q.push_back({r, res[15:0]});
        end
        #1;
    endtask

    task automatic idle(input logic g, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, SHF_ASH, '0, '0, 1'b0, g);
    endtask

    // Monitor: stall, status and the write port against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", 32'(stall), 32'(exp_q.size() >= DEPTH));
            check("stat", 32'(stat), 32'(exp_stat));
            check("we", 32'(we), 32'(exp_q.size() > (pend_v ? 1 : 0)));
            if (we && exp_q.size() > 0) begin
                check("wb_addr", 32'(addr), 32'(exp_q[0][AW+DW-1:DW]));
                check("wb_data", 32'(dt), 32'(exp_q[0][DW-1:0]));
                if (gnt) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        logic do_en;
        n_chk = 0;
        n_fail = 0;
        exp_stat = 3'b000;
        pend_v = 1'b0;
        pend_res = '0;
        rst_n = 1'b0;
        en = 1'b0; rn = '0; clr = 1'b0; gnt = 1'b0;
        xb_dt = '0; sv_in = 1'b0; sz_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(we), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_stat", 32'(stat), 0);
        check("rst_dt", 32'(dt), 0);
        rst_n = 1'b1;

        // Arithmetic shift right, immediate grant.
        step(1'b1, 4'd3, SHF_ASH, 16'hf000, 16'hfffc, 1'b0, 1'b1);
        idle(1'b1, 3);
        check("t1_stat", 32'(stat), 32'h0);

        // Overflowing shift, then a clean op: SS stays sticky until cleared.
        step(1'b1, 4'd5, SHF_ASH, 16'h4000, 16'h0001, 1'b0, 1'b1);
        idle(1'b1, 1);
        check("t2_stat_a", 32'(stat), 32'h6);
        step(1'b1, 4'd6, SHF_ASH, 16'h0001, 16'h0000, 1'b0, 1'b1);
        idle(1'b1, 1);
        check("t2_stat_b", 32'(stat), 32'h4);
        step(1'b0, '0, SHF_ASH, '0, '0, 1'b1, 1'b1);
        check("t2_stat_c", 32'(stat), 32'h0);
        idle(1'b1, 2);

        // Back-pressure: two ops with no grant, then drain in order.
        step(1'b1, 4'd1, SHF_ROT, 16'h1234, 16'h0004, 1'b0, 1'b0);
        step(1'b1, 4'd2, SHF_ROT, 16'h8001, 16'h0001, 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 3);

        // Clear coinciding with an overflowing capture: set wins.
        step(1'b1, 4'd7, SHF_ASH, 16'h4000, 16'h0001, 1'b0, 1'b1);
        step(1'b0, '0, SHF_ASH, '0, '0, 1'b1, 1'b1);
        check("t4_ss", 32'(stat[SHF_STAT_SS]), 1);
        idle(1'b1, 2);

        // Leading-zero count of zero.
        step(1'b1, 4'd9, SHF_LZ, 16'h0000, 16'h0000, 1'b0, 1'b1);
        idle(1'b1, 1);
        check("t5_stat", 32'(stat), 32'h6);
        idle(1'b1, 2);

        // Random traffic with random grant and clear.
        for (int i = 0; i < 400; i++) begin
            do_en = ($urandom_range(0, 3) != 0) && (exp_q.size() < DEPTH);
            step(do_en, 4'($urandom), shf_cls_e'($urandom_range(0, 3)), 16'($urandom),
                 16'($urandom_range(0, 40) - 20), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        idle(1'b1, 3);

        // Reset with two entries buffered discards them.
        step(1'b1, 4'd10, SHF_ASH, 16'h0f0f, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 4'd11, SHF_ASH, 16'h4000, 16'h0001, 1'b0, 1'b0);
        idle(1'b0, 2);
        rst_n = 1'b0;
        exp_q.delete();
        pend_v = 1'b0;
        exp_stat = 3'b000;
        #2;
        check("t6_we", 32'(we), 0);
        check("t6_stall", 32'(stall), 0);
        check("t6_stat", 32'(stat), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1, 4);

        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            idle(1'b1, 1);
            k++;
        end
        check("drain_left", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
